lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem_pkg.sv | 31 +++
 rtl/lsu_load_ext.sv | 29 ++
 rtl/lsu_mem.sv | 158 +++++++++++++++
 tb/tb_lsu_mem.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the load/store unit memory stage.
//   XLEN            : datapath width (64)
//   SZ_B..SZ_D      : req_size encodings (byte, half, word, double)
//   EXC_*           : resp_exc codes
//   lsu_state_e     : FSM state encoding (IDLE -> MEM -> RESP)
//   size_bytes()    : number of bytes covered by a size encoding
package lsu_mem_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ACCESS   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // 1, 2, 4 or 8 bytes for SZ_B..SZ_D
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension.
// Ports:
//   size        in  2     access size (SZ_B..SZ_D)
//   is_unsigned in  1     1 = zero-extend, 0 = sign-extend
//   raw         in  XLEN  RAM read data, lowest byte at bit 0
//   ext         out XLEN  extended result
module lsu_load_ext
  import lsu_mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_B: ext = is_unsigned ? {{(XLEN-8){1'b0}}, raw[7:0]}
                              : {{(XLEN-8){raw[7]}}, raw[7:0]};
      SZ_H: ext = is_unsigned ? {{(XLEN-16){1'b0}}, raw[15:0]}
                              : {{(XLEN-16){raw[15]}}, raw[15:0]};
      SZ_W: ext = is_unsigned ? {{(XLEN-32){1'b0}}, raw[31:0]}
                              : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit memory stage: accepts one EX-stage request, performs a
// single-cycle access to a combinational-read data RAM, and returns the
// (extended) load data or an exception code to WB.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_store, req_size,
//   req_unsigned, req_addr,
//   req_wdata                      request fields
//   ram_addr, ram_wen, ram_ren,
//   ram_byte_en, ram_wdata         RAM control, active only in MEM
//   ram_rdata                      RAM combinational read data
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_exc           response payload
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int RAM_SIZE    = 8192,
  parameter int ALIGN_CHECK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] ram_addr,
  output logic            ram_wen,
  output logic            ram_ren,
  output logic [7:0]      ram_byte_en,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_exc
);

  lsu_state_e state_reg, state_next;

  logic            store_reg;
  logic [1:0]      size_reg;
  logic            unsigned_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] rdata_reg;
  logic [1:0]      exc_reg;

  // ---------------------------------------------------------------
  // Fault detection on the incoming request
  // ---------------------------------------------------------------
  logic [3:0]      req_bytes;
  logic            misaligned;
  logic [XLEN:0]   req_end;
  logic            out_of_range;
  logic [1:0]      fault_exc;

  assign req_bytes    = size_bytes(req_size);
  assign misaligned   = (ALIGN_CHECK != 0) &&
                        ((req_addr & XLEN'(req_bytes - 4'd1)) != '0);
  // One extra bit so addresses near 2^XLEN cannot wrap into range
  assign req_end      = {1'b0, req_addr} + (XLEN+1)'(req_bytes);
  assign out_of_range = req_end > (XLEN+1)'(RAM_SIZE);
  assign fault_exc    = misaligned   ? EXC_MISALIGN :
                        out_of_range ? EXC_ACCESS   : EXC_NONE;

  logic accept;
  logic mem_active;

  // ---------------------------------------------------------------
  // Byte lanes: lane gi enabled when gi < access size in bytes
  // ---------------------------------------------------------------
  logic [7:0] lane_en;
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_en[gi] = (4'(gi) < size_bytes(size_reg));
  end

  logic [XLEN-1:0] load_ext;

  lsu_load_ext u_load_ext (
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .raw         (ram_rdata),
    .ext         (load_ext)
  );

  // ---------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = (fault_exc != EXC_NONE) ? ST_RESP : ST_MEM;
        end
      end
      ST_MEM:  state_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset during MEM must not let the pending write reach the RAM on the
  // reset edge, so the RAM strobes are gated by rst combinationally.
  assign mem_active  = (state_reg == ST_MEM) && !rst;
  assign ram_ren     = mem_active && !store_reg;
  assign ram_wen     = mem_active &&  store_reg;
  assign ram_addr    = mem_active ? addr_reg  : '0;
  assign ram_wdata   = mem_active ? wdata_reg : '0;
  assign ram_byte_en = mem_active ? lane_en   : 8'h00;

  assign resp_rdata  = rdata_reg;
  assign resp_exc    = exc_reg;

  // ---------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      store_reg    <= 1'b0;
      size_reg     <= SZ_B;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      exc_reg      <= EXC_NONE;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        store_reg    <= req_store;
        size_reg     <= req_size;
        unsigned_reg <= req_unsigned;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        exc_reg      <= fault_exc;
        // stores and faults report zero data
        rdata_reg    <= '0;
      end
      if (state_reg == ST_MEM && !store_reg) begin
        rdata_reg <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem. Two instances share clk/rst:
// index 0 with ALIGN_CHECK=1, index 1 with ALIGN_CHECK=0. Each has its own
// byte-array RAM; a separate reference memory predicts load results.
module tb_lsu_mem;
  localparam int RAM_SIZE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_store    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [63:0] req_addr     [2];
  logic [63:0] req_wdata    [2];
  logic [63:0] ram_addr     [2];
  logic        ram_wen      [2];
  logic        ram_ren      [2];
  logic [7:0]  ram_byte_en  [2];
  logic [63:0] ram_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [63:0] resp_rdata   [2];
  logic [1:0]  resp_exc     [2];

  logic [7:0] ref_mem [2][RAM_SIZE];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [7:0]  mem [RAM_SIZE];
    logic [63:0] rdata_w;

    initial for (int k = 0; k < RAM_SIZE; k++) mem[k] = 8'h00;

    always_comb begin
      rdata_w = '0;
      for (int k = 0; k < 8; k++)
        if (ram_addr[gi] + 64'(k) < 64'(RAM_SIZE))
          rdata_w[8*k +: 8] = mem[ram_addr[gi] + 64'(k)];
    end

    always @(posedge clk) begin
      if (ram_wen[gi])
        for (int k = 0; k < 8; k++)
          if (ram_byte_en[gi][k] && (ram_addr[gi] + 64'(k) < 64'(RAM_SIZE)))
            mem[ram_addr[gi] + 64'(k)] <= ram_wdata[gi][8*k +: 8];
    end

    lsu_mem #(.RAM_SIZE(RAM_SIZE), .ALIGN_CHECK((gi == 0) ? 1 : 0)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[gi]),
      .req_ready    (req_ready[gi]),
      .req_store    (req_store[gi]),
      .req_size     (req_size[gi]),
      .req_unsigned (req_unsigned[gi]),
      .req_addr     (req_addr[gi]),
      .req_wdata    (req_wdata[gi]),
      .ram_addr     (ram_addr[gi]),
      .ram_wen      (ram_wen[gi]),
      .ram_ren      (ram_ren[gi]),
      .ram_byte_en  (ram_byte_en[gi]),
      .ram_wdata    (ram_wdata[gi]),
      .ram_rdata    (rdata_w),
      .resp_valid   (resp_valid[gi]),
      .resp_ready   (resp_ready[gi]),
      .resp_rdata   (resp_rdata[gi]),
      .resp_exc     (resp_exc[gi])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d, driven and sampled on negedges.
  task automatic txn(input int d, input bit st, input logic [1:0] sz, input bit uns,
                     input logic [63:0] a, input logic [63:0] wd, input int hold,
                     output logic [63:0] got);
    int          n;
    int          exp_exc;
    logic [63:0] exp_rd;
    logic [63:0] exp_be;
    n = 1 << sz;
    if (d == 0 && (a % 64'(n)) != 0)        exp_exc = 1;
    else if (a + 64'(n) > 64'(RAM_SIZE))    exp_exc = 2;
    else                                    exp_exc = 0;
    exp_be = (64'd1 << n) - 64'd1;
    exp_rd = '0;
    if (!st && exp_exc == 0) begin
      for (int k = 0; k < n; k++) exp_rd = exp_rd | (64'(ref_mem[d][a + 64'(k)]) << (8 * k));
      if (!uns && exp_rd[8*n-1]) exp_rd = exp_rd | (~64'd0 << (8 * n));
    end

    chk("req_ready_before", 64'(req_ready[d]), 64'd1);
    req_store[d] = st; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[d] = 1'b0;
    if (exp_exc == 0) begin
      chk("mem_ren",     64'(ram_ren[d]), 64'(!st));
      chk("mem_wen",     64'(ram_wen[d]), 64'(st));
      chk("mem_byte_en", 64'(ram_byte_en[d]), exp_be);
      chk("mem_addr",    ram_addr[d], a);
      if (st) chk("mem_wdata", ram_wdata[d], wd);
      chk("mem_resp_valid", 64'(resp_valid[d]), 64'd0);
      chk("mem_req_ready",  64'(req_ready[d]), 64'd0);
      @(negedge clk);
    end else begin
      chk("fault_no_ren", 64'(ram_ren[d]), 64'd0);
      chk("fault_no_wen", 64'(ram_wen[d]), 64'd0);
    end
    got = resp_rdata[d];
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("resp_valid", 64'(resp_valid[d]), 64'd1);
      chk("resp_exc",   64'(resp_exc[d]), 64'(exp_exc));
      chk("resp_rdata", resp_rdata[d], exp_rd);
      chk("resp_req_ready", 64'(req_ready[d]), 64'd0);
      chk("resp_no_ram", 64'(ram_ren[d] | ram_wen[d]), 64'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("after_resp_valid", 64'(resp_valid[d]), 64'd0);
    chk("after_req_ready",  64'(req_ready[d]), 64'd1);
    if (st && exp_exc == 0)
      for (int k = 0; k < n; k++) ref_mem[d][a + 64'(k)] = wd[8*k +: 8];
    $display("txn dut%0d %s size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h exc=%0d",
             d, st ? "ST" : "LD", sz, uns, a, wd, got, exp_exc);
  endtask

  initial begin
    logic [63:0] got;
    int          d;
    logic [1:0]  sz;
    logic [63:0] a;
    logic [63:0] wd;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_store[i] = 0; req_size[i] = 0; req_unsigned[i] = 0;
      req_addr[i] = 0; req_wdata[i] = 0; resp_ready[i] = 0;
      for (int k = 0; k < RAM_SIZE; k++) ref_mem[i][k] = 8'h00;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready",  64'(req_ready[i]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
      chk("rst_resp_rdata", resp_rdata[i], 64'd0);
      chk("rst_resp_exc",   64'(resp_exc[i]), 64'd0);
      chk("rst_ram_ctrl",   64'({ram_wen[i], ram_ren[i], ram_byte_en[i]}), 64'd0);
      chk("rst_ram_addr",   ram_addr[i], 64'd0);
      chk("rst_ram_wdata",  ram_wdata[i], 64'd0);
    end

    // Double store/load round trip
    txn(0, 1, 2'd3, 0, 64'h10, 64'h8877665544332211, 0, got);
    txn(0, 0, 2'd3, 0, 64'h10, 64'h0, 0, got);
    chk("ld_0x10", got, 64'h8877665544332211);
    // Byte store, signed and unsigned byte loads
    txn(0, 1, 2'd0, 0, 64'h21, 64'hFF, 0, got);
    txn(0, 0, 2'd0, 0, 64'h21, 64'h0, 0, got);
    chk("lb_0x21", got, 64'hFFFFFFFFFFFFFFFF);
    txn(0, 0, 2'd0, 1, 64'h21, 64'h0, 0, got);
    chk("lbu_0x21", got, 64'h00000000000000FF);
    // Misalignment and its priority over access fault
    txn(0, 0, 2'd2, 0, 64'h102, 64'h0, 0, got);
    txn(0, 1, 2'd2, 0, 64'd8190, 64'h1234, 0, got);
    // Top-of-RAM boundary
    txn(0, 0, 2'd3, 0, 64'd8184, 64'h0, 0, got);
    txn(1, 0, 2'd3, 0, 64'd8188, 64'h0, 0, got);
    txn(1, 1, 2'd2, 0, 64'h102, 64'hCAFEBABE, 0, got);
    txn(1, 0, 2'd2, 0, 64'h102, 64'h0, 0, got);
    chk("lw_misaligned_ok", got, 64'hFFFFFFFFCAFEBABE);
    // Backpressure: hold resp_ready low for five cycles
    txn(0, 0, 2'd1, 1, 64'h10, 64'h0, 5, got);
    chk("lhu_hold", got, 64'h0000000000002211);

    // Reset during MEM of a store must abort it
    txn(0, 1, 2'd3, 0, 64'h40, 64'h0123456789ABCDEF, 0, got);
    req_store[0] = 1; req_size[0] = 2'd3; req_unsigned[0] = 0;
    req_addr[0] = 64'h40; req_wdata[0] = 64'hDEADBEEFDEADBEEF; req_valid[0] = 1;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 0;
    chk("abort_mem_wen", 64'(ram_wen[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_wen_gated", 64'(ram_wen[0]), 64'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready",  64'(req_ready[0]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_resp", 64'(resp_valid[0]), 64'd0);
      @(negedge clk);
    end
    txn(0, 0, 2'd3, 0, 64'h40, 64'h0, 0, got);
    chk("abort_mem_kept", got, 64'h0123456789ABCDEF);

    // Randomized traffic on both instances
    for (int i = 0; i < 300; i++) begin
      d  = $urandom_range(0, 1);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 64'(RAM_SIZE - 16 + $urandom_range(0, 23));
      else                           a = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
          $urandom_range(0, 2), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
